// File: rtl/burst_pulse_gen.sv
// Burst pulse generator: on a start request emits cfg_count pulses of cfg_width
// high cycles, each preceded by cfg_gap low cycles, with busy/done/aborted status.
module burst_pulse_gen #(
  parameter int unsigned CNT_W = 4,
  parameter int unsigned TIM_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             abort,
  input  logic [CNT_W-1:0] cfg_count,
  input  logic [TIM_W-1:0] cfg_gap,
  input  logic [TIM_W-1:0] cfg_width,
  input  logic             cfg_repeat,
  output logic             busy,
  output logic             pulse,
  output logic [CNT_W-1:0] pulse_idx,
  output logic             done,
  output logic             aborted
);

  typedef enum logic [1:0] {IDLE, GAP, PULSE, WAIT_LOW} state_t;

  state_t           state_q, state_d;
  logic [TIM_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] idx_d;
  logic [CNT_W-1:0] cnt_l;
  logic [TIM_W-1:0] gap_l, wid_l;
  logic             rep_l;
  logic             start, finish, cancel;
  logic             busy_d, pulse_d;

  // State, timer, latched config and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      pulse_idx <= '0;
      cnt_l     <= '0;
      gap_l     <= '0;
      wid_l     <= '0;
      rep_l     <= 1'b0;
      busy      <= 1'b0;
      pulse     <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      pulse_idx <= idx_d;
      if (start) begin
        cnt_l <= cfg_count;
        gap_l <= cfg_gap;
        wid_l <= (cfg_width == '0) ? TIM_W'(1) : cfg_width;
        rep_l <= cfg_repeat;
      end
      busy    <= busy_d;
      pulse   <= pulse_d;
      done    <= finish;
      aborted <= cancel;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    idx_d   = pulse_idx;
    start   = 1'b0;
    finish  = 1'b0;
    cancel  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (en && (cfg_count != '0)) begin
          start   = 1'b1;
          idx_d   = '0;
          timer_d = '0;
          state_d = (cfg_gap != '0) ? GAP : PULSE;
        end
      end
      GAP: begin
        if (abort) begin
          cancel  = 1'b1;
          timer_d = '0;
          state_d = WAIT_LOW;
        end else if (timer_q == gap_l - TIM_W'(1)) begin
          timer_d = '0;
          state_d = PULSE;
        end else begin
          timer_d = timer_q + TIM_W'(1);
        end
      end
      PULSE: begin
        if (abort) begin
          cancel  = 1'b1;
          timer_d = '0;
          state_d = WAIT_LOW;
        end else if (timer_q == wid_l - TIM_W'(1)) begin
          timer_d = '0;
          if (pulse_idx == cnt_l - CNT_W'(1)) begin
            finish  = 1'b1;
            state_d = rep_l ? IDLE : WAIT_LOW;
          end else begin
            idx_d   = pulse_idx + CNT_W'(1);
            state_d = (gap_l != '0) ? GAP : PULSE;
          end
        end else begin
          timer_d = timer_q + TIM_W'(1);
        end
      end
      WAIT_LOW: begin
        if (!en) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they align with it
  always_comb begin
    busy_d  = (state_d == GAP) || (state_d == PULSE);
    pulse_d = (state_d == PULSE);
  end

endmodule

// File: tb/tb_burst_pulse_gen.sv
// Randomised bench for burst_pulse_gen against a burst-position reference model.
module tb_burst_pulse_gen;
  localparam int CNT_W = 4;
  localparam int TIM_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en, abort, cfg_repeat;
  logic [CNT_W-1:0] cfg_count;
  logic [TIM_W-1:0] cfg_gap, cfg_width;
  logic             busy, pulse, done, aborted;
  logic [CNT_W-1:0] pulse_idx;

  burst_pulse_gen #(.CNT_W(CNT_W), .TIM_W(TIM_W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .abort(abort),
    .cfg_count(cfg_count), .cfg_gap(cfg_gap), .cfg_width(cfg_width),
    .cfg_repeat(cfg_repeat), .busy(busy), .pulse(pulse),
    .pulse_idx(pulse_idx), .done(done), .aborted(aborted)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: tracks position k (1-based cycle) inside the burst
  int unsigned      m_mode;  // 0 idle, 1 running, 2 waiting for en low
  int unsigned      m_k, m_c, m_g, m_w;
  logic             m_rep;
  logic             exp_busy, exp_pulse, exp_done, exp_abt;
  logic [CNT_W-1:0] exp_idx;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode <= 0; m_k <= 0; m_c <= 0; m_g <= 0; m_w <= 1; m_rep <= 1'b0;
      exp_busy <= 1'b0; exp_pulse <= 1'b0; exp_done <= 1'b0; exp_abt <= 1'b0;
      exp_idx <= '0;
    end else begin
      exp_done <= 1'b0;
      exp_abt  <= 1'b0;
      case (m_mode)
        0: if (en && cfg_count != 0) begin
          m_c <= cfg_count; m_g <= cfg_gap;
          m_w <= (cfg_width == 0) ? 1 : cfg_width;
          m_rep <= cfg_repeat; m_k <= 1; m_mode <= 1;
          exp_busy <= 1'b1; exp_pulse <= (cfg_gap == 0); exp_idx <= '0;
        end
        1: if (abort) begin
          m_mode <= 2; exp_busy <= 1'b0; exp_pulse <= 1'b0; exp_abt <= 1'b1;
        end else if (m_k == m_c * (m_g + m_w)) begin
          m_mode <= m_rep ? 0 : 2; exp_busy <= 1'b0; exp_pulse <= 1'b0; exp_done <= 1'b1;
        end else begin
          m_k <= m_k + 1;
          exp_pulse <= (m_k % (m_g + m_w)) >= m_g;
          exp_idx <= CNT_W'(m_k / (m_g + m_w));
        end
        default: if (!en) m_mode <= 0;
      endcase
    end
  end

  int n_busy = 0, n_pulse = 0, n_done = 0, n_abt = 0;

  always @(negedge clk) begin
    check_eq("busy", busy, exp_busy);
    check_eq("pulse", pulse, exp_pulse);
    check_eq("pulse_idx", pulse_idx, exp_idx);
    check_eq("done", done, exp_done);
    check_eq("aborted", aborted, exp_abt);
    check_eq("excl", done & aborted, 0);
    n_busy  <= n_busy + busy;
    n_pulse <= n_pulse + pulse;
    n_done  <= n_done + done;
    n_abt   <= n_abt + aborted;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_cfg(input int c, input int g, input int w, input logic r);
    cfg_count = CNT_W'(c); cfg_gap = TIM_W'(g); cfg_width = TIM_W'(w); cfg_repeat = r;
  endtask

  int sb, sp, sd, sa;
  task automatic snap();
    sb = n_busy; sp = n_pulse; sd = n_done; sa = n_abt;
  endtask

  task automatic wait_pulse(input string tag, input int idx);
    int i;
    i = 0;
    while (i < 300 && !(pulse && pulse_idx == CNT_W'(idx))) begin
      @(negedge clk);
      i++;
    end
    check_eq(tag, pulse && pulse_idx == CNT_W'(idx), 1);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; abort = 1'b0;
    set_cfg(15, 30, 1, 1'b0);
    #2;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_pulse", pulse, 0);
    check_eq("rst_idx", pulse_idx, 0);
    cyc(3);
    rst_n = 1'b1;
    cyc(2);

    // 15 pulses, gap 30, width 1, one-shot
    snap(); en = 1'b1; cyc(1); en = 1'b0; cyc(475);
    check_eq("t1_busy_cycles", n_busy - sb, 465);
    check_eq("t1_pulses", n_pulse - sp, 15);
    check_eq("t1_done", n_done - sd, 1);

    // en held in one-shot: no restart until en seen low
    set_cfg(2, 1, 1, 1'b0);
    snap(); en = 1'b1; cyc(20);
    check_eq("t1b_no_rearm", n_busy - sb, 4);
    en = 1'b0; cyc(1); en = 1'b1; cyc(1); en = 1'b0; cyc(10);
    check_eq("t1b_rearm", n_busy - sb, 8);

    // back-to-back pulse cycles
    set_cfg(3, 0, 4, 1'b0);
    snap(); en = 1'b1; cyc(1); en = 1'b0; cyc(16);
    check_eq("t2_pulses", n_pulse - sp, 12);
    check_eq("t2_done", n_done - sd, 1);

    // auto-repeat, config change takes effect on next burst
    set_cfg(2, 2, 1, 1'b1);
    snap(); en = 1'b1; cyc(3); cfg_gap = 5; cyc(40); en = 1'b0; cyc(20);
    check_eq("t3_done", n_done - sd, 4);

    // abort at second pulse, en held
    set_cfg(4, 3, 2, 1'b0);
    snap(); en = 1'b1;
    wait_pulse("t4_wait", 1);
    abort = 1'b1; cyc(1); abort = 1'b0; cyc(15);
    check_eq("t4_aborted", n_abt - sa, 1);
    check_eq("t4_no_done", n_done - sd, 0);
    en = 1'b0; cyc(2); en = 1'b1; cyc(1); en = 1'b0; cyc(30);
    check_eq("t4_restart_done", n_done - sd, 1);

    // abort during last pulse cycle wins over done
    set_cfg(1, 0, 3, 1'b0);
    snap(); en = 1'b1; cyc(1); en = 1'b0; cyc(2); abort = 1'b1; cyc(1); abort = 1'b0; cyc(5);
    check_eq("t5_last_abort", n_abt - sa, 1);
    check_eq("t5_last_no_done", n_done - sd, 0);

    // count 0 ignored, width 0 acts as 1
    set_cfg(0, 1, 1, 1'b1);
    snap(); en = 1'b1; cyc(10); en = 1'b0; cyc(2);
    check_eq("t6_cnt0", n_busy - sb, 0);
    set_cfg(2, 1, 0, 1'b0);
    snap(); en = 1'b1; cyc(1); en = 1'b0; cyc(8);
    check_eq("t6_w0_pulses", n_pulse - sp, 2);

    // asynchronous reset mid-pulse
    set_cfg(5, 2, 6, 1'b0);
    en = 1'b1;
    wait_pulse("t7_wait", 2);
    #3 rst_n = 1'b0;
    #1;
    check_eq("t7_rst_busy", busy, 0);
    check_eq("t7_rst_pulse", pulse, 0);
    check_eq("t7_rst_idx", pulse_idx, 0);
    cyc(2); rst_n = 1'b1; cyc(45); en = 1'b0; cyc(5);

    // randomised traffic
    for (int it = 0; it < 30; it++) begin
      set_cfg($urandom_range(0, 5), $urandom_range(0, 4), $urandom_range(0, 4), 1'($urandom_range(0, 1)));
      for (int c = 0; c < int'($urandom_range(5, 60)); c++) begin
        en = ($urandom_range(0, 3) != 0);
        abort = ($urandom_range(0, 15) == 0);
        if ($urandom_range(0, 7) == 0)
          set_cfg($urandom_range(0, 5), $urandom_range(0, 4), $urandom_range(0, 4), 1'($urandom_range(0, 1)));
        cyc(1);
      end
    end
    en = 1'b0; abort = 1'b0; cyc(80);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
